// File: rtl/mem_pkg.sv
// Shared types and widths for the SRAM memory-stage controller.
// Six-state access sequencer enum plus SRAM/word bus widths.
package mem_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_W      = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } sram_state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one SRAM half-access; sync load to 0, last when count hits ACCESS_CYCLES-1.
// Zero latency on last (decoded from the register); no flow control.
module sram_phase_counter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= 4'd0;
        end else begin
            r_count <= r_count + 4'd1;
        end
    end

    assign last = (r_count == 4'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit load/store into two 16-bit SRAM accesses of ACCESS_CYCLES each.
// ready is low for 2N+1 cycles after a request is seen and high in the single DONE cycle.
module sram_mem_controller
    import mem_pkg::*;
#(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [WORD_W-1:0]      address,
    input  logic [WORD_W-1:0]      write_data,
    output logic [WORD_W-1:0]      read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in
);

    sram_state_t r_state;
    sram_state_t w_state_nxt;

    logic [WORD_W-1:0]      r_addr;
    logic [WORD_W-1:0]      r_wdata;
    logic [WORD_W-1:0]      r_read_data;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic                   r_sram_we_n;
    logic [SRAM_DATA_W-1:0] r_sram_dq_out;
    logic                   r_sram_dq_oe;

    logic                   w_last;
    logic                   w_load;
    logic                   w_capture;
    logic [WORD_W-1:0]      w_addr_src;
    logic [WORD_W-1:0]      w_wdata_src;
    logic [16:0]            w_word;
    logic [SRAM_ADDR_W-1:0] w_sram_addr_nxt;
    logic                   w_sram_we_n_nxt;
    logic [SRAM_DATA_W-1:0] w_sram_dq_out_nxt;
    logic                   w_sram_dq_oe_nxt;

    sram_phase_counter #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_phase (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (MEM_R_EN) begin
                    w_state_nxt = RD_LO;
                end else if (MEM_W_EN) begin
                    w_state_nxt = WR_LO;
                end
            end
            RD_LO:   if (w_last) w_state_nxt = RD_HI;
            RD_HI:   if (w_last) w_state_nxt = DONE;
            WR_LO:   if (w_last) w_state_nxt = WR_HI;
            WR_HI:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Every state change enters a fresh state, so it also restarts the phase count.
    assign w_load    = (w_state_nxt != r_state);
    assign w_capture = (r_state == IDLE) && (w_state_nxt != IDLE);

    // On the IDLE exit edge the pin registers must use the live request, not the capture.
    assign w_addr_src  = (r_state == IDLE) ? address    : r_addr;
    assign w_wdata_src = (r_state == IDLE) ? write_data : r_wdata;
    assign w_word      = 17'((w_addr_src - 32'(BASE_ADDR)) >> 2);

    always_comb begin
        w_sram_addr_nxt   = '0;
        w_sram_we_n_nxt   = 1'b1;
        w_sram_dq_out_nxt = '0;
        w_sram_dq_oe_nxt  = 1'b0;
        case (w_state_nxt)
            RD_LO: w_sram_addr_nxt = {w_word, 1'b0};
            RD_HI: w_sram_addr_nxt = {w_word, 1'b1};
            WR_LO: begin
                w_sram_addr_nxt   = {w_word, 1'b0};
                w_sram_we_n_nxt   = 1'b0;
                w_sram_dq_out_nxt = w_wdata_src[15:0];
                w_sram_dq_oe_nxt  = 1'b1;
            end
            WR_HI: begin
                // Hold we_n high for the first WR_HI cycle so the new address settles first.
                w_sram_addr_nxt   = {w_word, 1'b1};
                w_sram_we_n_nxt   = (ACCESS_CYCLES >= 2) && (r_state != WR_HI);
                w_sram_dq_out_nxt = w_wdata_src[31:16];
                w_sram_dq_oe_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_sram_addr   <= '0;
            r_sram_we_n   <= 1'b1;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr  <= address;
                r_wdata <= write_data;
            end
            r_sram_addr   <= w_sram_addr_nxt;
            r_sram_we_n   <= w_sram_we_n_nxt;
            r_sram_dq_out <= w_sram_dq_out_nxt;
            r_sram_dq_oe  <= w_sram_dq_oe_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= '0;
        end else if (w_last && (r_state == RD_LO)) begin
            r_read_data[15:0] <= sram_dq_in;
        end else if (w_last && (r_state == RD_HI)) begin
            r_read_data[31:16] <= sram_dq_in;
        end
    end

    assign ready       = ((r_state == IDLE) && !MEM_R_EN && !MEM_W_EN) || (r_state == DONE);
    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_we_n   = r_sram_we_n;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: fixed vector table, randomized ops against a word-level
// memory model, and hand-written reset/idle sequences.
module tb_sram_mem_controller;

    localparam int N    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    always #5 clk = ~clk;

    sram_mem_controller #(
        .BASE_ADDR(BASE),
        .ACCESS_CYCLES(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in)
    );

    // Pin-level asynchronous SRAM: written at the end of every we_n-low cycle.
    logic [15:0] sram_mem [0:262143];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
            sram_mem[6]    = 16'hA5A5;
            sram_mem[7]    = 16'h5A5A;
            sram_mem[2000] = 16'h1111;
            sram_mem[2001] = 16'h2222;
            mem_init = 1'b1;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr] = sram_dq_out;
        end
    end

    assign sram_dq_in = sram_mem[sram_addr];

    // Word-granular reference memory and last-load register.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        bit          chain;
        logic [31:0] e_rd;
        logic [31:0] e_lo;
        logic [31:0] e_hi;
        logic [31:0] e_dqlo;
        logic [31:0] e_dqhi;
        int          e_we;
    } vec_t;

    vec_t tbl [6];

    function automatic int word_of(input logic [31:0] a);
        return int'(((a - 32'(BASE)) >> 2) & 32'h1FFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic go_idle();
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // Drives one request from posedge+1 and observes it until ready (DONE) or a cycle budget.
    task automatic run_txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] o_rd, output logic [31:0] o_lo, output logic [31:0] o_hi,
                           output logic [31:0] o_dqlo, output logic [31:0] o_dqhi,
                           output int o_stall, output int o_welow, output int o_done);
        MEM_R_EN = r; MEM_W_EN = w; address = a; write_data = wd;
        o_rd = 32'hFFFF_FFFF; o_lo = 32'hFFFF_FFFF; o_hi = 32'hFFFF_FFFF;
        o_dqlo = 32'hFFFF_FFFF; o_dqhi = 32'hFFFF_FFFF;
        o_stall = 0; o_welow = 0; o_done = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!ready) o_stall++;
            if (!sram_we_n) o_welow++;
            if (c == 1) begin
                o_lo = 32'(sram_addr);
                o_dqlo = 32'(sram_dq_out);
            end
            if (c == N + 1) begin
                o_hi = 32'(sram_addr);
                o_dqhi = 32'(sram_dq_out);
            end
            if (ready) begin
                o_done = c;
                o_rd = read_data;
            end
            @(posedge clk); #1;
            if (o_done >= 0) break;
        end
    endtask

    task automatic apply_and_check(input string tag, input logic r, input logic w,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] e_rd, input logic [31:0] e_lo,
                                   input logic [31:0] e_hi, input logic [31:0] e_dqlo,
                                   input logic [31:0] e_dqhi, input int e_we);
        logic [31:0] g_rd, g_lo, g_hi, g_dqlo, g_dqhi;
        int g_stall, g_we, g_done;
        run_txn(r, w, a, wd, g_rd, g_lo, g_hi, g_dqlo, g_dqhi, g_stall, g_we, g_done);
        chk({tag, "_done_cycle"}, 32'(g_done), 32'(2 * N + 1));
        chk({tag, "_stall"}, 32'(g_stall), 32'(2 * N + 1));
        chk({tag, "_read_data"}, g_rd, e_rd);
        chk({tag, "_addr_lo"}, g_lo, e_lo);
        chk({tag, "_addr_hi"}, g_hi, e_hi);
        chk({tag, "_dq_lo"}, g_dqlo, e_dqlo);
        chk({tag, "_dq_hi"}, g_dqhi, e_dqhi);
        chk({tag, "_we_low"}, 32'(g_we), 32'(e_we));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, w;
        logic [31:0] a, wd, e_rd;
        int          wi, e_we;
        bit          chain;

        tbl[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, 32'h0,       32'd4,     32'd5,     32'hBEEF, 32'hDEAD, 3};
        tbl[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,       1'b1, 32'hDEADBEEF, 32'd4,     32'd5,     32'h0,    32'h0,    0};
        tbl[2] = '{1'b1, 1'b1, 32'd1039, 32'hFFFFFFFF, 1'b0, 32'h5A5AA5A5, 32'd6,     32'd7,     32'h0,    32'h0,    0};
        tbl[3] = '{1'b0, 1'b1, 32'd1020, 32'h13579BDF, 1'b0, 32'h5A5AA5A5, 32'h3FFFE, 32'h3FFFF, 32'h9BDF, 32'h1357, 3};
        tbl[4] = '{1'b1, 1'b0, 32'd1022, 32'h0,       1'b0, 32'h13579BDF, 32'h3FFFE, 32'h3FFFF, 32'h0,    32'h0,    0};
        tbl[5] = '{1'b1, 1'b0, 32'd1039, 32'h0,       1'b0, 32'h5A5AA5A5, 32'd6,     32'd7,     32'h0,    32'h0,    0};

        ref_mem[3]    = 32'h5A5AA5A5;
        ref_mem[1000] = 32'h22221111;
        ref_rd        = 32'h0;

        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; write_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_we_n", 32'(sram_we_n), 32'd1);
            chk("rst_oe", 32'(sram_dq_oe), 32'd0);
            chk("rst_read_data", read_data, 32'd0);
            chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].chain) go_idle();
            apply_and_check($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd,
                            tbl[i].e_rd, tbl[i].e_lo, tbl[i].e_hi, tbl[i].e_dqlo, tbl[i].e_dqhi,
                            tbl[i].e_we);
            wi = word_of(tbl[i].a);
            if (tbl[i].r) ref_rd = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
            else          ref_mem[wi] = tbl[i].wd;
        end

        // Store request held high across DONE: must become a second, separate store.
        go_idle();
        apply_and_check("hold1", 1'b0, 1'b1, 32'd1044, 32'hAAAA5555, ref_rd, 32'd10, 32'd11, 32'h5555, 32'hAAAA, 3);
        apply_and_check("hold2", 1'b0, 1'b1, 32'd1044, 32'hAAAA5555, ref_rd, 32'd10, 32'd11, 32'h5555, 32'hAAAA, 3);
        ref_mem[5] = 32'hAAAA5555;

        for (int i = 0; i < 40; i++) begin
            r     = 1'($urandom_range(0, 1));
            w     = r ? 1'($urandom_range(0, 1)) : 1'b1;
            a     = 32'(BASE - 32) + 32'($urandom_range(0, 255));
            wd    = $urandom;
            chain = 1'($urandom_range(0, 1));
            wi    = word_of(a);
            if (r) begin
                e_rd   = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
                ref_rd = e_rd;
                e_we   = 0;
            end else begin
                e_rd        = ref_rd;
                ref_mem[wi] = wd;
                e_we        = (N >= 2) ? 2 * N - 1 : 2 * N;
            end
            if (!chain) go_idle();
            apply_and_check($sformatf("rnd%0d", i), r, w, a, wd, e_rd,
                            32'(wi * 2), 32'(wi * 2 + 1),
                            r ? 32'h0 : {16'h0, wd[15:0]}, r ? 32'h0 : {16'h0, wd[31:16]}, e_we);
        end

        // Asynchronous reset in the first RD_HI cycle abandons the load.
        go_idle();
        MEM_R_EN = 1'b1; address = 32'd5024;
        for (int c = 0; c <= N + 1; c++) begin
            @(negedge clk);
            if (c < N + 1) begin
                @(posedge clk); #1;
            end
        end
        chk("midrst_lo_loaded", {16'h0, read_data[15:0]}, 32'h1111);
        chk("midrst_hi_addr", 32'(sram_addr), 32'd2001);
        MEM_R_EN = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        ref_rd = 32'h0;
        for (int c = 0; c < 2 * N + 2; c++) begin
            @(negedge clk);
            chk("postrst_ready", 32'(ready), 32'd1);
            chk("postrst_read_data", read_data, 32'd0);
            chk("postrst_sram_addr", 32'(sram_addr), 32'd0);
        end
        @(posedge clk); #1;
        apply_and_check("postrst_load", 1'b1, 1'b0, 32'd5024, 32'h0, 32'h22221111,
                        32'd2000, 32'd2001, 32'h0, 32'h0, 0);
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
